servo_move_controller: RTL and testbench

SERVO_MOVE_CONTROLLER -- requirements
Module: servo_move_controller

---
 rtl/servo_pkg.sv | 34 +++
 rtl/servo_pwm_gen.sv | 36 +++
 rtl/servo_move_controller.sv | 122 ++++++++++++
 tb/tb_servo_move_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// servo_pkg: default servo timing constants, ramp FSM state encoding and position-to-width helper.
// Revision: 1.0
package servo_pkg;

    localparam int DEF_FRAME_CYCLES = 1000000;
    localparam int DEF_PW_MIN       = 50000;
    localparam int DEF_PW_PER_LSB   = 200;
    localparam int DEF_POS_MAX      = 250;
    localparam int DEF_STEP         = 2000;

    localparam int PW_W  = 20;
    localparam int POS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_HOLD   = 2'd2
    } servo_state_t;

    // Out-of-range codes saturate at pos_max rather than wrapping the pulse width.
    function automatic logic [PW_W-1:0] pos_to_pw(
        input logic [POS_W-1:0] pos,
        input int               pos_max,
        input int               pw_min,
        input int               pw_per_lsb
    );
        int p;
        p = (int'(pos) > pos_max) ? pos_max : int'(pos);
        return PW_W'(pw_min + p * pw_per_lsb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// servo_pwm_gen: free-running frame counter, end-of-frame strobe and registered pulse compare.
// Revision: 1.0
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic            clock_clk,
    input  logic            reset_low,
    input  logic            enable,
    input  logic            active,
    input  logic [PW_W-1:0] cur_pw,
    output logic            boundary,
    output logic            pwm_out
);

    localparam int               CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign boundary = (count == CNT_LAST);

    always_ff @(posedge clock_clk) begin
        if (!reset_low) begin
            count   <= '0;
            pwm_out <= 1'b0;
        end else begin
            count   <= boundary ? '0 : count + CNT_W'(1);
            pwm_out <= enable && active && (32'(count) < 32'(cur_pw));
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_move_controller.sv
`default_nettype none
// servo_move_controller: two-channel command arbitration, target register and frame-synchronous ramp FSM.
// Revision: 1.0
module servo_move_controller
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int PW_MIN       = DEF_PW_MIN,
    parameter int PW_PER_LSB   = DEF_PW_PER_LSB,
    parameter int POS_MAX      = DEF_POS_MAX,
    parameter int STEP         = DEF_STEP
) (
    input  logic             clock_clk,
    input  logic             reset_low,
    input  logic             enable,
    input  logic             req0_valid,
    input  logic [POS_W-1:0] req0_pos,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [POS_W-1:0] req1_pos,
    output logic             req1_ready,
    output logic             pwm_out,
    output logic             busy,
    output logic [PW_W-1:0]  cur_pw
);

    localparam logic [PW_W-1:0] PW_RESET = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0] STEP_PW  = PW_W'(STEP);

    servo_state_t     state;
    servo_state_t     state_nxt;
    logic             boundary;
    logic             take0;
    logic             take1;
    logic             take;
    logic             pending;
    logic             busy_nxt;
    logic [POS_W-1:0] acc_pos;
    logic [PW_W-1:0]  target;
    logic [PW_W-1:0]  stepped;
    logic [PW_W-1:0]  cur_pw_nxt;

    assign req0_ready = reset_low;
    assign req1_ready = reset_low & ~req0_valid;
    assign take0      = req0_valid & req0_ready;
    assign take1      = req1_valid & req1_ready;
    assign take       = take0 | take1;
    assign acc_pos    = take0 ? req0_pos : req1_pos;

    // One ramp increment toward the target, landing exactly on it when within STEP.
    always_comb begin
        stepped = target;
        if (target > cur_pw) begin
            if ((target - cur_pw) > STEP_PW) begin
                stepped = cur_pw + STEP_PW;
            end
        end else if ((cur_pw - target) > STEP_PW) begin
            stepped = cur_pw - STEP_PW;
        end
    end

    always_comb begin
        state_nxt  = state;
        cur_pw_nxt = cur_pw;
        if (boundary && enable) begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state_nxt  = ST_HOLD;
                        cur_pw_nxt = target;
                    end
                end
                ST_HOLD: begin
                    if (target != cur_pw) begin
                        state_nxt = ST_MOVING;
                    end
                end
                ST_MOVING: begin
                    cur_pw_nxt = stepped;
                    if (stepped == target) begin
                        state_nxt = ST_HOLD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        // Computed from next-cycle values so busy lines up with the registered state.
        busy_nxt = (state_nxt == ST_MOVING) || ((state_nxt == ST_IDLE) && (pending || take));
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_low) begin
            state   <= ST_IDLE;
            target  <= PW_RESET;
            cur_pw  <= PW_RESET;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cur_pw <= cur_pw_nxt;
            busy   <= busy_nxt;
            if (take) begin
                target  <= pos_to_pw(acc_pos, POS_MAX, PW_MIN, PW_PER_LSB);
                pending <= 1'b1;
            end
        end
    end

    servo_pwm_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_pwm_gen (
        .clock_clk (clock_clk),
        .reset_low (reset_low),
        .enable    (enable),
        .active    (state != ST_IDLE),
        .cur_pw    (cur_pw),
        .boundary  (boundary),
        .pwm_out   (pwm_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_servo_move_controller.sv
`default_nettype none
// tb_servo_move_controller: directed spec scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0
module tb_servo_move_controller;

    localparam int FRAME = 1000;
    localparam int PWMIN = 50;
    localparam int PWLSB = 2;
    localparam int PMAX  = 250;
    localparam int STEPV = 100;

    logic        clock_clk = 1'b0;
    logic        reset_low;
    logic        enable;
    logic        req0_valid;
    logic        req1_valid;
    logic [7:0]  req0_pos;
    logic [7:0]  req1_pos;
    logic        req0_ready;
    logic        req1_ready;
    logic        pwm_out;
    logic        busy;
    logic [19:0] cur_pw;

    always #5 clock_clk = ~clock_clk;

    servo_move_controller #(
        .FRAME_CYCLES (FRAME),
        .PW_MIN       (PWMIN),
        .PW_PER_LSB   (PWLSB),
        .POS_MAX      (PMAX),
        .STEP         (STEPV)
    ) dut (
        .clock_clk  (clock_clk),
        .reset_low  (reset_low),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_pos   (req0_pos),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_pos   (req1_pos),
        .req1_ready (req1_ready),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .cur_pw     (cur_pw)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position of the frame, commanded width, and whether the servo has started / is ramping.
    int m_cnt = 0;
    int m_cur = PWMIN;
    int m_target = PWMIN;
    bit m_have = 1'b0;
    bit m_started = 1'b0;
    bit m_moving = 1'b0;
    bit m_pwm = 1'b0;
    bit m_busy = 1'b0;

    int dut_hi = 0;
    int mod_hi = 0;
    int cyc_bad = 0;
    int last_hi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick();
        bit bnd;
        int d;
        int p;
        if (!reset_low) begin
            m_cnt = 0; m_cur = PWMIN; m_target = PWMIN;
            m_have = 0; m_started = 0; m_moving = 0; m_pwm = 0; m_busy = 0;
            return;
        end
        m_pwm = enable && m_started && (m_cnt < m_cur);
        bnd   = (m_cnt == FRAME - 1);
        if (bnd && enable) begin
            if (!m_started) begin
                if (m_have) begin
                    m_started = 1;
                    m_cur     = m_target;
                end
            end else if (!m_moving) begin
                if (m_target != m_cur) m_moving = 1;
            end else begin
                d = m_target - m_cur;
                if (d > STEPV) d = STEPV;
                if (d < -STEPV) d = -STEPV;
                m_cur += d;
                if (m_cur == m_target) m_moving = 0;
            end
        end
        m_cnt = bnd ? 0 : m_cnt + 1;
        if (req0_valid || req1_valid) begin
            p = req0_valid ? int'(req0_pos) : int'(req1_pos);
            if (p > PMAX) p = PMAX;
            m_target = PWMIN + p * PWLSB;
            m_have   = 1;
        end
        m_busy = m_moving || (!m_started && m_have);
    endtask

    task automatic frame_end();
        check("frame_pwm_high", 32'(dut_hi), 32'(mod_hi));
        check("frame_cur_pw", 32'(cur_pw), 32'(m_cur));
        check("frame_busy", 32'(busy), 32'(m_busy));
        check("frame_cycle_agree", 32'(cyc_bad), 32'(0));
        check("frame_req0_ready", 32'(req0_ready), 32'(1));
        check("frame_req1_ready", 32'(req1_ready), 32'(!req0_valid));
        last_hi = dut_hi;
        dut_hi  = 0;
        mod_hi  = 0;
        cyc_bad = 0;
    endtask

    task automatic tick();
        @(posedge clock_clk);
        model_tick();
        #1;
        if (!reset_low) begin
            dut_hi = 0; mod_hi = 0; cyc_bad = 0;
        end else begin
            if (pwm_out === 1'b1) dut_hi++;
            if (m_pwm) mod_hi++;
            if (pwm_out !== m_pwm || busy !== m_busy || cur_pw !== 20'(m_cur)) cyc_bad++;
            if (m_cnt == 0) frame_end();
        end
    endtask

    task automatic next_boundary();
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (m_cnt != 0 && guard < FRAME + 5);
        if (m_cnt != 0) check("boundary_timeout", 32'(guard), 32'(FRAME));
    endtask

    task automatic send(input int ch, input logic [7:0] pos);
        if (ch == 0) begin
            req0_valid = 1'b1; req0_pos = pos;
        end else begin
            req1_valid = 1'b1; req1_pos = pos;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] seq [4];
        int busy_frames;

        reset_low = 1'b0; enable = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_pos = '0; req1_pos = '0;
        repeat (4) tick();
        check("rst_pwm", 32'(pwm_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cur_pw", 32'(cur_pw), 32'(50));
        check("rst_req0_ready", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));

        // First command loads directly at the next boundary.
        reset_low = 1'b1; enable = 1'b1;
        repeat (10) tick();
        send(1, 8'd100);
        check("idle_pending_busy", 32'(busy), 32'(1));
        check("idle_cur_pw", 32'(cur_pw), 32'(50));
        next_boundary();
        check("first_load_cur_pw", 32'(cur_pw), 32'(250));
        check("first_load_busy", 32'(busy), 32'(0));
        next_boundary();
        check("hold_pwm_high_250", 32'(last_hi), 32'(250));

        // Command landing on the boundary cycle is deferred to the following boundary.
        while (m_cnt != FRAME - 1) tick();
        req0_valid = 1'b1; req0_pos = 8'd250;
        tick();
        req0_valid = 1'b0;
        check("bnd_cmd_deferred_cur", 32'(cur_pw), 32'(250));
        check("bnd_cmd_deferred_busy", 32'(busy), 32'(0));
        busy_frames = 0;
        for (int i = 0; i < 4; i++) begin
            next_boundary();
            seq[i] = cur_pw;
            if (busy === 1'b1) busy_frames++;
        end
        check("ramp_up_0", 32'(seq[0]), 32'(250));
        check("ramp_up_1", 32'(seq[1]), 32'(350));
        check("ramp_up_2", 32'(seq[2]), 32'(450));
        check("ramp_up_3", 32'(seq[3]), 32'(550));
        check("ramp_busy_frames", 32'(busy_frames), 32'(3));

        // Priority arbitration: req0 wins, req1 lands one cycle later and overwrites.
        repeat (37) tick();
        req0_valid = 1'b1; req0_pos = 8'd20; req1_valid = 1'b1; req1_pos = 8'd200;
        #1;
        check("arb_req1_blocked", 32'(req1_ready), 32'(0));
        check("arb_req0_ready", 32'(req0_ready), 32'(1));
        tick();
        req0_valid = 1'b0;
        #1;
        check("arb_req1_ready_after", 32'(req1_ready), 32'(1));
        tick();
        req1_valid = 1'b0;
        next_boundary();
        check("arb_enter_moving_busy", 32'(busy), 32'(1));
        next_boundary();
        check("arb_final_cur_pw", 32'(cur_pw), 32'(450));
        check("arb_final_busy", 32'(busy), 32'(0));

        // Ramp down, then clamped ramp up frozen mid-way by enable.
        send(1, 8'd0);
        repeat (5) next_boundary();
        check("ramp_down_cur_pw", 32'(cur_pw), 32'(50));
        repeat (20) tick();
        send(0, 8'd255);
        repeat (3) next_boundary();
        check("ramp_before_freeze", 32'(cur_pw), 32'(250));
        repeat (100) tick();
        enable = 1'b0;
        repeat (2) next_boundary();
        check("freeze_cur_pw", 32'(cur_pw), 32'(250));
        check("freeze_busy", 32'(busy), 32'(1));
        check("freeze_pwm_high", 32'(last_hi), 32'(0));
        repeat (50) tick();
        enable = 1'b1;
        next_boundary();
        check("resume_step", 32'(cur_pw), 32'(350));
        repeat (2) next_boundary();
        check("clamp_final_cur_pw", 32'(cur_pw), 32'(550));
        check("clamp_final_busy", 32'(busy), 32'(0));

        // Reset in the middle of a pulse abandons everything.
        repeat (200) tick();
        check("pre_reset_pwm_high", 32'(pwm_out), 32'(1));
        reset_low = 1'b0;
        tick();
        check("mid_reset_pwm", 32'(pwm_out), 32'(0));
        check("mid_reset_cur_pw", 32'(cur_pw), 32'(50));
        check("mid_reset_busy", 32'(busy), 32'(0));
        reset_low = 1'b1;
        repeat (2) next_boundary();
        check("post_reset_no_pulse", 32'(last_hi), 32'(0));
        send(0, 8'd10);
        next_boundary();
        check("post_reset_load", 32'(cur_pw), 32'(70));
        check("post_reset_busy", 32'(busy), 32'(0));

        // Randomized traffic, including boundary-cycle commands, enable toggles and one reset.
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                req0_valid = ($urandom_range(0, 399) == 0);
                req0_pos   = 8'($urandom);
                req1_valid = ($urandom_range(0, 299) == 0);
                req1_pos   = 8'($urandom);
                if (m_cnt == FRAME - 1 && $urandom_range(0, 2) == 0) req1_valid = 1'b1;
                if ($urandom_range(0, 1999) == 0) enable = ~enable;
                reset_low = !(f == 12 && c == 333);
                tick();
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset_low  = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
